// File: rtl/skeleton_test_top_pkg.sv
// Shared constants, encodings and the built-in test program for the demo processor.
package skeleton_test_top_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_AW     = 5;
    localparam int unsigned FIELD_W    = 5;
    localparam int unsigned IMM_W      = 17;
    localparam int unsigned PC_W       = 6;
    localparam int unsigned ROM_AW     = 5;
    localparam int unsigned DMEM_AW    = 12;
    localparam int unsigned DMEM_WORDS = 4096;
    localparam int unsigned NUM_REGS   = 32;

    localparam int unsigned OPC_LSB = 27;
    localparam int unsigned RD_LSB  = 22;
    localparam int unsigned RS_LSB  = 17;
    localparam int unsigned RT_LSB  = 12;
    localparam int unsigned SH_LSB  = 7;
    localparam int unsigned ALU_LSB = 2;

    typedef enum logic [4:0] {
        OP_R    = 5'b00000,
        OP_ADDI = 5'b00101,
        OP_SW   = 5'b00111,
        OP_LW   = 5'b01000
    } opcode_e;

    typedef enum logic [4:0] {
        ALU_ADD = 5'b00000,
        ALU_SUB = 5'b00001,
        ALU_AND = 5'b00010,
        ALU_OR  = 5'b00011,
        ALU_SLL = 5'b00100,
        ALU_SRA = 5'b00101
    } alu_op_e;

    function automatic logic [XLEN-1:0] enc_r(input logic [4:0] rd, input logic [4:0] rs,
                                              input logic [4:0] rt, input logic [4:0] sh,
                                              input alu_op_e alu);
        return {OP_R, rd, rs, rt, sh, alu, 2'b00};
    endfunction

    function automatic logic [XLEN-1:0] enc_i(input opcode_e op, input logic [4:0] rd,
                                              input logic [4:0] rs, input logic [IMM_W-1:0] imm);
        return {op, rd, rs, imm};
    endfunction

    // Even words compute result j into $(j+1); odd words from 3 store $(j+1) to dmem[j].
    function automatic logic [XLEN-1:0] rom_word(input logic [ROM_AW-1:0] idx);
        logic [XLEN-1:0] w;
        w = '0;
        if (idx[0] && (idx > 5'd1)) begin
            w = enc_i(OP_SW, {1'b0, idx[4:1]}, 5'd0, IMM_W'(idx[4:1] - 4'd1));
        end else begin
            case (idx)
                5'd2:    w = enc_i(OP_ADDI, 5'd1, 5'd0, 17'd65535);
                5'd4:    w = enc_r(5'd2,  5'd1,  5'd0, 5'd15, ALU_SLL);
                5'd6:    w = enc_r(5'd3,  5'd1,  5'd2, 5'd0,  ALU_OR);
                5'd8:    w = enc_r(5'd4,  5'd1,  5'd1, 5'd0,  ALU_SUB);
                5'd10:   w = enc_r(5'd5,  5'd4,  5'd3, 5'd0,  ALU_AND);
                5'd12:   w = enc_r(5'd6,  5'd0,  5'd0, 5'd0,  ALU_ADD);
                5'd14:   w = enc_i(OP_ADDI, 5'd7, 5'd0, 17'd1);
                5'd16:   w = enc_r(5'd8,  5'd7,  5'd7, 5'd0,  ALU_ADD);
                5'd18:   w = enc_r(5'd9,  5'd8,  5'd7, 5'd0,  ALU_ADD);
                5'd20:   w = enc_r(5'd10, 5'd9,  5'd0, 5'd2,  ALU_SRA);
                5'd22:   w = enc_r(5'd11, 5'd9,  5'd9, 5'd0,  ALU_SUB);
                5'd24:   w = enc_r(5'd12, 5'd1,  5'd0, 5'd0,  ALU_AND);
                5'd26:   w = enc_r(5'd13, 5'd3,  5'd7, 5'd0,  ALU_ADD);
                5'd28:   w = enc_r(5'd14, 5'd13, 5'd0, 5'd31, ALU_SRA);
                5'd30:   w = enc_r(5'd15, 5'd14, 5'd7, 5'd0,  ALU_ADD);
                default: w = '0;
            endcase
        end
        return w;
    endfunction

endpackage

// File: rtl/skeleton_test_top_if.sv
// Register-file access bus between the processor core and its register file.
interface skeleton_test_top_if;
    import skeleton_test_top_pkg::*;

    logic              we;
    logic [REG_AW-1:0] waddr;
    logic [XLEN-1:0]   wdata;
    logic [REG_AW-1:0] raddr_a;
    logic [REG_AW-1:0] raddr_b;
    logic [XLEN-1:0]   rdata_a;
    logic [XLEN-1:0]   rdata_b;

    modport master (output we, waddr, wdata, raddr_a, raddr_b, input rdata_a, rdata_b);
    modport slave  (input we, waddr, wdata, raddr_a, raddr_b, output rdata_a, rdata_b);
endinterface

// File: rtl/skeleton_test_top_regfile_32x32.sv
// 32x32 register file: two combinational read ports, one write port, $0 hardwired to zero.
module regfile_32x32
    import skeleton_test_top_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    skeleton_test_top_if.slave  bus
);

    logic [XLEN-1:0] regs_q [NUM_REGS];
    logic [XLEN-1:0] regs_d [NUM_REGS];

    always_comb begin
        regs_d = regs_q;
        if (bus.we && (bus.waddr != '0)) begin
            regs_d[bus.waddr] = bus.wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    assign bus.rdata_a = (bus.raddr_a == '0) ? '0 : regs_q[bus.raddr_a];
    assign bus.rdata_b = (bus.raddr_b == '0) ? '0 : regs_q[bus.raddr_b];

endmodule

// File: rtl/skeleton_test_top.sv
// Four-clock-per-instruction demo processor with built-in program ROM, data RAM and register file.
module skeleton_test_top
    import skeleton_test_top_pkg::*;
(
    input  logic              clock,
    input  logic              ctrl_reset,
    output logic              imem_clock,
    output logic              dmem_clock,
    output logic              processor_clock,
    output logic              regfile_clock,
    output logic [XLEN-1:0]   data_readRegA,
    output logic [XLEN-1:0]   data_readRegB,
    output logic [XLEN-1:0]   q_dmem,
    output logic [XLEN-1:0]   q_imem,
    output logic [REG_AW-1:0] ctrl_writeReg,
    output logic [REG_AW-1:0] ctrl_readRegA,
    output logic [REG_AW-1:0] ctrl_readRegB,
    output logic [XLEN-1:0]   data_writeReg,
    output logic              ctrl_writeEnable
);

    logic [1:0]         c_q, c_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               commit_c;

    logic [FIELD_W-1:0] opcode, rd, rs, rt, shamt, aluop, alu_sel;
    logic [IMM_W-1:0]   imm;
    logic [XLEN-1:0]    imm_ext, alu_b, alu_y;
    logic               is_r, is_addi, is_sw, is_lw;
    logic [DMEM_AW-1:0] dmem_addr;

    logic [XLEN-1:0]    dmem_q [DMEM_WORDS];

    skeleton_test_top_if rf_bus ();

    assign imem_clock      = clock;
    assign dmem_clock      = clock;
    assign processor_clock = c_q[1];
    assign regfile_clock   = c_q[1];

    // The last phase of each instruction window is the only one that changes architectural state.
    assign commit_c = (c_q == 2'd3);

    always_comb begin
        c_d  = c_q + 2'd1;
        pc_d = pc_q;
        if (commit_c) begin
            pc_d = pc_q + 6'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            c_q  <= '0;
            pc_q <= '0;
        end else begin
            c_q  <= c_d;
            pc_q <= pc_d;
        end
    end

    // Upper half of the ROM is all nops.
    assign q_imem = pc_q[PC_W-1] ? '0 : rom_word(pc_q[ROM_AW-1:0]);

    always_comb begin
        opcode  = q_imem[OPC_LSB +: FIELD_W];
        rd      = q_imem[RD_LSB  +: FIELD_W];
        rs      = q_imem[RS_LSB  +: FIELD_W];
        rt      = q_imem[RT_LSB  +: FIELD_W];
        shamt   = q_imem[SH_LSB  +: FIELD_W];
        aluop   = q_imem[ALU_LSB +: FIELD_W];
        imm     = q_imem[IMM_W-1:0];
        imm_ext = {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};

        is_r    = (opcode == OP_R);
        is_addi = (opcode == OP_ADDI);
        is_sw   = (opcode == OP_SW);
        is_lw   = (opcode == OP_LW);

        ctrl_readRegA    = rs;
        ctrl_readRegB    = is_sw ? rd : rt;
        ctrl_writeReg    = rd;
        ctrl_writeEnable = is_r || is_addi || is_lw;

        alu_b   = is_r ? data_readRegB : imm_ext;
        alu_sel = is_r ? aluop : FIELD_W'(ALU_ADD);
        alu_y   = '0;
        case (alu_sel)
            ALU_ADD: alu_y = data_readRegA + alu_b;
            ALU_SUB: alu_y = data_readRegA - alu_b;
            ALU_AND: alu_y = data_readRegA & alu_b;
            ALU_OR:  alu_y = data_readRegA | alu_b;
            ALU_SLL: alu_y = data_readRegA << shamt;
            ALU_SRA: alu_y = XLEN'($signed(data_readRegA) >>> shamt);
            default: alu_y = '0;
        endcase

        dmem_addr     = DMEM_AW'(data_readRegA + imm_ext);
        data_writeReg = is_lw ? q_dmem : alu_y;
    end

    assign q_dmem = dmem_q[dmem_addr];

    // Data RAM is deliberately not reset; a reset edge suppresses the store.
    always_ff @(posedge clock) begin
        if (!ctrl_reset && commit_c && is_sw) begin
            dmem_q[dmem_addr] <= data_readRegB;
        end
    end

    assign rf_bus.we      = ctrl_writeEnable && commit_c;
    assign rf_bus.waddr   = ctrl_writeReg;
    assign rf_bus.wdata   = data_writeReg;
    assign rf_bus.raddr_a = ctrl_readRegA;
    assign rf_bus.raddr_b = ctrl_readRegB;
    assign data_readRegA  = rf_bus.rdata_a;
    assign data_readRegB  = rf_bus.rdata_b;

    regfile_32x32 u_regfile (
        .clk (clock),
        .rst (ctrl_reset),
        .bus (rf_bus)
    );

endmodule

// File: tb/tb_skeleton_test_top.sv
// Directed bench for skeleton_test_top: program results, decode peeks, RAM contents, mid-run reset.
module tb_skeleton_test_top;
    import skeleton_test_top_pkg::*;

    logic              clock;
    logic              ctrl_reset;
    logic              imem_clock, dmem_clock, processor_clock, regfile_clock;
    logic [XLEN-1:0]   data_readRegA, data_readRegB, q_dmem, q_imem, data_writeReg;
    logic [REG_AW-1:0] ctrl_writeReg, ctrl_readRegA, ctrl_readRegB;
    logic              ctrl_writeEnable;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    logic [XLEN-1:0] exp_res [15] = '{32'd65535, 32'd2147450880, 32'h7FFF_FFFF, 32'd0, 32'd0,
                                      32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd0, 32'd0,
                                      32'h8000_0000, 32'hFFFF_FFFF, 32'd0};

    skeleton_test_top_if obs ();

    skeleton_test_top dut (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .imem_clock       (imem_clock),
        .dmem_clock       (dmem_clock),
        .processor_clock  (processor_clock),
        .regfile_clock    (regfile_clock),
        .data_readRegA    (data_readRegA),
        .data_readRegB    (data_readRegB),
        .q_dmem           (q_dmem),
        .q_imem           (q_imem),
        .ctrl_writeReg    (ctrl_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_writeReg    (data_writeReg),
        .ctrl_writeEnable (ctrl_writeEnable)
    );

    assign obs.we      = ctrl_writeEnable;
    assign obs.waddr   = ctrl_writeReg;
    assign obs.wdata   = data_writeReg;
    assign obs.raddr_a = ctrl_readRegA;
    assign obs.raddr_b = ctrl_readRegB;
    assign obs.rdata_a = data_readRegA;
    assign obs.rdata_b = data_readRegB;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
        edge_n++;
    endtask

    task automatic run_to(input int target);
        while (edge_n < target) step();
    endtask

    task automatic test_reset();
        ctrl_reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (q_imem !== 32'd0) begin
            errors++; $display("FAIL reset_q_imem: got %h expected %h", q_imem, 32'd0);
        end
        checks++;
        if (obs.rdata_a !== 32'd0 || obs.rdata_b !== 32'd0) begin
            errors++; $display("FAIL reset_reads: got A=%h B=%h expected 0/0", obs.rdata_a, obs.rdata_b);
        end
        checks++;
        if (processor_clock !== 1'b0 || regfile_clock !== 1'b0) begin
            errors++; $display("FAIL reset_pclk: got %b/%b expected 0/0", processor_clock, regfile_clock);
        end
        @(negedge clock);
        ctrl_reset = 1'b0;
        edge_n = 0;
    endtask

    task automatic test_first_addi();
        run_to(9);
        checks++;
        if (obs.we !== 1'b1 || obs.waddr !== 5'd1 || obs.wdata !== 32'd65535) begin
            errors++;
            $display("FAIL addi_peek: got we=%b rd=%0d wd=%h expected we=1 rd=1 wd=0000ffff",
                     obs.we, obs.waddr, obs.wdata);
        end
    endtask

    task automatic test_results(input int lo, input int hi);
        for (int j = lo; j <= hi; j++) begin
            run_to(13 + 8 * j);
            checks++;
            if (obs.rdata_a !== 32'd0 || obs.rdata_b !== exp_res[j]) begin
                errors++;
                $display("FAIL result_%0d: got A=%h B=%h expected A=0 B=%h",
                         j, obs.rdata_a, obs.rdata_b, exp_res[j]);
            end
        end
    endtask

    task automatic test_overflow();
        run_to(105);
        checks++;
        if (obs.wdata !== 32'h8000_0000 || obs.waddr !== 5'd13 || obs.we !== 1'b1) begin
            errors++;
            $display("FAIL overflow_write: got we=%b rd=%0d wd=%h expected we=1 rd=13 wd=80000000",
                     obs.we, obs.waddr, obs.wdata);
        end
        checks++;
        if (obs.rdata_a !== 32'h7FFF_FFFF || obs.rdata_b !== 32'd1) begin
            errors++;
            $display("FAIL overflow_operands: got A=%h B=%h expected 7fffffff/00000001",
                     obs.rdata_a, obs.rdata_b);
        end
    endtask

    task automatic test_dmem();
        run_to(130);
        for (int j = 0; j < 15; j++) begin
            checks++;
            if (dut.dmem_q[j] !== exp_res[j]) begin
                errors++;
                $display("FAIL dmem_%0d: got %h expected %h", j, dut.dmem_q[j], exp_res[j]);
            end
        end
    endtask

    task automatic test_proc_clock();
        logic exp_pc;
        for (int i = 0; i < 8; i++) begin
            step();
            exp_pc = ((edge_n % 4) >= 2);
            checks++;
            if (processor_clock !== exp_pc || regfile_clock !== exp_pc) begin
                errors++;
                $display("FAIL proc_clock_e%0d: got %b/%b expected %b",
                         edge_n, processor_clock, regfile_clock, exp_pc);
            end
        end
    endtask

    task automatic test_midreset();
        @(negedge clock);
        ctrl_reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        ctrl_reset = 1'b0;
        edge_n = 0;
        run_to(41);
        checks++;
        if (obs.waddr !== 5'd5 || obs.we !== 1'b1) begin
            errors++; $display("FAIL midreset_slot10: got rd=%0d we=%b expected rd=5 we=1", obs.waddr, obs.we);
        end
        @(negedge clock);
        ctrl_reset = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if (q_imem !== 32'd0) begin
            errors++; $display("FAIL midreset_q_imem: got %h expected 0", q_imem);
        end
        checks++;
        if (dut.u_regfile.regs_q[1] !== 32'd0 || dut.u_regfile.regs_q[5] !== 32'd0) begin
            errors++;
            $display("FAIL midreset_regs: got r1=%h r5=%h expected 0/0",
                     dut.u_regfile.regs_q[1], dut.u_regfile.regs_q[5]);
        end
        checks++;
        if (dut.dmem_q[0] !== 32'd65535) begin
            errors++; $display("FAIL midreset_dmem_kept: got %h expected 0000ffff", dut.dmem_q[0]);
        end
        @(negedge clock);
        ctrl_reset = 1'b0;
        edge_n = 0;
        test_results(0, 14);
    endtask

    initial begin
        ctrl_reset = 1'b1;
        test_reset();
        test_first_addi();
        test_results(0, 11);
        test_overflow();
        test_results(12, 14);
        test_dmem();
        test_proc_clock();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
